// File: rtl/adpcm_speed_avg.sv
// ADPCM adaptation-speed averages: DMS (FILTA) and DML (FILTB) state with FUNCTF mapping and valid/ready handshake.
// Optional SPEED_AVG_SAMPLE_CNT_EN adds a wrapping count of completed updates on sample_cnt.
module adpcm_speed_avg #(
  parameter int DMS_W = 12,
  parameter int DML_W = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       rate,
  input  logic [4:0]       I,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             homing,
  output logic [2:0]       FI,
  output logic [DMS_W-1:0] DMS,
  output logic [DML_W-1:0] DML,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SPEED_AVG_SAMPLE_CNT_EN
  ,
  output logic [15:0]      sample_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, MAP, UPDATE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [4:0]       i_q;
  logic [1:0]       rate_q;
  logic [2:0]       fi_q;
  logic [DMS_W-1:0] dms_q, dms_nxt;
  logic [DML_W-1:0] dml_q, dml_nxt;

  logic signed [DMS_W:0] dms_dif, dms_sx;
  logic signed [DML_W:0] dml_dif, dml_sx;
  logic                  unused_sx;

  // Fold the sign into a magnitude, then look up FI per rate.
  function automatic logic [2:0] functf(input logic [1:0] r, input logic [4:0] code);
    logic [3:0] im;
    logic [2:0] fi;
    im = '0;
    fi = '0;
    case (r)
      2'd0: begin
        im = {3'b000, (code[1] ? ~code[0] : code[0])};
        fi = im[0] ? 3'd7 : 3'd0;
      end
      2'd1: begin
        im = {2'b00, (code[2] ? ~code[1:0] : code[1:0])};
        case (im[1:0])
          2'd0:    fi = 3'd0;
          2'd1:    fi = 3'd1;
          2'd2:    fi = 3'd2;
          default: fi = 3'd7;
        endcase
      end
      2'd2: begin
        im = {1'b0, (code[3] ? ~code[2:0] : code[2:0])};
        case (im[2:0])
          3'd0, 3'd1, 3'd2: fi = 3'd0;
          3'd3, 3'd4, 3'd5: fi = 3'd1;
          3'd6:             fi = 3'd3;
          default:          fi = 3'd7;
        endcase
      end
      default: begin
        im = code[4] ? ~code[3:0] : code[3:0];
        case (im)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4:  fi = 3'd0;
          4'd5, 4'd6, 4'd7, 4'd8, 4'd9:  fi = 3'd1;
          4'd10:                         fi = 3'd2;
          4'd11:                         fi = 3'd3;
          4'd12:                         fi = 3'd4;
          4'd13:                         fi = 3'd5;
          default:                       fi = 3'd6;
        endcase
      end
    endcase
    return fi;
  endfunction

  // FILTA / FILTB: one extra bit of headroom holds the signed difference; the
  // sum wraps naturally at the state width.
  always_comb begin
    dms_dif = {1'b0, fi_q, {(DMS_W-3){1'b0}}} - {1'b0, dms_q};
    dms_sx  = dms_dif >>> 5;
    dms_nxt = dms_q + dms_sx[DMS_W-1:0];
    dml_dif = {1'b0, fi_q, {(DML_W-3){1'b0}}} - {1'b0, dml_q};
    dml_sx  = dml_dif >>> 7;
    dml_nxt = dml_q + dml_sx[DML_W-1:0];
  end

  assign unused_sx = dms_sx[DMS_W] ^ dml_sx[DML_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MAP;
      end
      MAP:    state_d = UPDATE;
      UPDATE: state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (homing) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q    <= '0;
      rate_q <= '0;
      fi_q   <= '0;
      dms_q  <= '0;
      dml_q  <= '0;
    end else if (homing) begin
      fi_q  <= '0;
      dms_q <= '0;
      dml_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          i_q    <= I;
          rate_q <= rate;
        end
        MAP:    fi_q <= functf(rate_q, i_q);
        UPDATE: begin
          dms_q <= dms_nxt;
          dml_q <= dml_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef SPEED_AVG_SAMPLE_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cnt_q <= '0;
    else if (homing)              cnt_q <= '0;
    else if (state_q == UPDATE)   cnt_q <= cnt_q + 16'd1;
  end
  assign sample_cnt = cnt_q;
`endif

  assign FI  = fi_q;
  assign DMS = dms_q;
  assign DML = dml_q;

endmodule

// File: tb/tb_adpcm_speed_avg.sv
// Directed self-checking bench for adpcm_speed_avg: FILTA/FILTB arithmetic, FUNCTF, handshake, homing, reset.
module tb_adpcm_speed_avg;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  rate;
  logic [4:0]  I;
  logic        in_valid, in_ready, homing, out_valid, out_ready;
  logic [2:0]  FI;
  logic [11:0] DMS;
  logic [13:0] DML;
`ifdef SPEED_AVG_SAMPLE_CNT_EN
  logic [15:0] sample_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  adpcm_speed_avg #(.DMS_W(12), .DML_W(14)) dut (
    .clk(clk), .reset_n(reset_n), .rate(rate), .I(I), .in_valid(in_valid),
    .in_ready(in_ready), .homing(homing), .FI(FI), .DMS(DMS), .DML(DML),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef SPEED_AVG_SAMPLE_CNT_EN
    , .sample_cnt(sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one code, scrambles rate/I after accept, returns edges from accept to out_valid.
  // Leaves the bench at a falling edge with the result in HOLD.
  task automatic send(input logic [1:0] r, input logic [4:0] code, output int l);
    int n;
    @(negedge clk);
    rate = r; I = code; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; rate = ~r; I = ~code;
    l = 1; n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(posedge clk); l++; n++; @(negedge clk); end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic home();
    @(negedge clk); homing = 1'b1;
    @(posedge clk); #1; homing = 1'b0;
  endtask

  logic [1:0] f_rate [6] = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1};
  logic [4:0] f_code [6] = '{5'd15, 5'd31, 5'd1, 5'd2, 5'd9, 5'd5};
  logic [2:0] f_fi   [6] = '{3'd6, 3'd0, 3'd7, 3'd2, 3'd3, 3'd2};

  initial begin
    reset_n = 1'b0; rate = '0; I = '0; in_valid = 1'b0; homing = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_dms", {20'd0, DMS}, 32'd0);
    chk("rst_dml", {18'd0, DML}, 32'd0);
    chk("rst_fi", {29'd0, FI}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // First 32k code I=7 from zero state
    send(2'd2, 5'd7, lat);
    chk("lat", lat, 32'd3);
    chk("t1_fi", {29'd0, FI}, 32'd7);
    chk("t1_dms", {20'd0, DMS}, 32'd112);
    chk("t1_dml", {18'd0, DML}, 32'd112);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;

    send(2'd2, 5'd7, lat);
    chk("t2_dms", {20'd0, DMS}, 32'd220);
    chk("t2_dml", {18'd0, DML}, 32'd223);
`ifdef SPEED_AVG_SAMPLE_CNT_EN
    chk("t2_cnt", {16'd0, sample_cnt}, 32'd2);
`endif
    @(posedge clk); #1;

    // Negative DIF: arithmetic shift floors toward -inf
    home();
    @(negedge clk);
    chk("home_dms", {20'd0, DMS}, 32'd0);
    chk("home_dml", {18'd0, DML}, 32'd0);
`ifdef SPEED_AVG_SAMPLE_CNT_EN
    chk("home_cnt", {16'd0, sample_cnt}, 32'd0);
`endif
    send(2'd2, 5'd7, lat);
    @(posedge clk); #1;
    send(2'd2, 5'd15, lat);
    chk("neg_fi", {29'd0, FI}, 32'd0);
    chk("neg_dms", {20'd0, DMS}, 32'd108);
    chk("neg_dml", {18'd0, DML}, 32'd111);
    @(posedge clk); #1;

    // FUNCTF: from a homed state DMS = DML = 16*FI
    for (int k = 0; k < 6; k++) begin
      home();
      send(f_rate[k], f_code[k], lat);
      chk("functf_fi", {29'd0, FI}, {29'd0, f_fi[k]});
      chk("functf_dms", {20'd0, DMS}, {25'd0, f_fi[k], 4'd0});
      chk("functf_dml", {18'd0, DML}, {25'd0, f_fi[k], 4'd0});
      @(posedge clk); #1;
    end

    // Backpressure with in_valid held high
    home();
    out_ready = 1'b0; rate = 2'd2; I = 5'd7; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_dms", {20'd0, DMS}, 32'd112);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("bp_no_double_dms", {20'd0, DMS}, 32'd112);
    chk("bp_no_double_dml", {18'd0, DML}, 32'd112);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

    // Homing during MAP discards the code in flight
    rate = 2'd2; I = 5'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; homing = 1'b1;
    @(posedge clk); #1 homing = 1'b0;
    @(negedge clk);
    chk("hmap_dms", {20'd0, DMS}, 32'd0);
    chk("hmap_dml", {18'd0, DML}, 32'd0);
    chk("hmap_fi", {29'd0, FI}, 32'd0);
    chk("hmap_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("hmap_valid", {31'd0, out_valid}, 32'd0);
    end

    // Homing beats a simultaneous in_valid in IDLE
    homing = 1'b1; in_valid = 1'b1; rate = 2'd2; I = 5'd7;
    @(posedge clk); #1 homing = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("hiv_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("hiv_valid", {31'd0, out_valid}, 32'd0);
    chk("hiv_dms", {20'd0, DMS}, 32'd0);

    // Asynchronous reset mid-transaction
    send(2'd2, 5'd7, lat);
    @(posedge clk); #1;
    rate = 2'd2; I = 5'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("arst_dms", {20'd0, DMS}, 32'd0);
    chk("arst_dml", {18'd0, DML}, 32'd0);
    chk("arst_fi", {29'd0, FI}, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("arst_after_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
